// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] PC_IDX = 4'd15;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back requests; push/pop must be qualified by full/empty.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PW = clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  wb_req_t     mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two producers,
// with per-register pending tracking. RF_WB_STATS_EN adds the conflict_cnt output.
module rf_wb_arbiter #(
  parameter int unsigned DATA_W     = rf_wb_pkg::DATA_W,
  parameter int unsigned ADDR_W     = rf_wb_pkg::ADDR_W,
  parameter int unsigned NUM_REGS   = int'(rf_wb_pkg::PC_IDX),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_valid,
  output logic                r0_ready,
  input  logic [ADDR_W-1:0]   r0_dest,
  input  logic [DATA_W-1:0]   r0_data,
  input  logic                r1_valid,
  output logic                r1_ready,
  input  logic [ADDR_W-1:0]   r1_dest,
  input  logic [DATA_W-1:0]   r1_data,
  output logic                wb_en,
  output logic [ADDR_W-1:0]   wb_dest,
  output logic [DATA_W-1:0]   wb_data,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                pc_wr_err
`ifdef RF_WB_STATS_EN
  ,
  output logic [31:0]         conflict_cnt
`endif
);

  import rf_wb_pkg::*;

  localparam int unsigned CW = clog2(2*FIFO_DEPTH+1);

  wb_req_t in0, in1, head0, head1;
  logic    full0, full1, empty0, empty1;
  logic    acc0, acc1, keep0, keep1;
  logic    gnt0, gnt1, rr;

  logic [CW-1:0] cnt     [NUM_REGS];
  logic [CW-1:0] cnt_nxt [NUM_REGS];

  assign r0_ready = !full0;
  assign r1_ready = !full1;
  assign acc0     = r0_valid && !full0;
  assign acc1     = r1_valid && !full1;
  // Out-of-range destinations still complete the handshake but are dropped.
  assign keep0    = acc0 && (int'(r0_dest) < int'(NUM_REGS));
  assign keep1    = acc1 && (int'(r1_dest) < int'(NUM_REGS));
  assign in0      = '{dest: r0_dest, data: r0_data};
  assign in1      = '{dest: r1_dest, data: r1_data};

  // rr == 0 favours req0 when both heads are present.
  assign gnt0 = !empty0 && (empty1 || !rr);
  assign gnt1 = !empty1 && (empty0 || rr);

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(keep0), .push_data(in0),
    .pop(gnt0), .head(head0), .full(full0), .empty(empty0)
  );

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(keep1), .push_data(in1),
    .pop(gnt1), .head(head1), .full(full1), .empty(empty1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en     <= 1'b0;
      wb_dest   <= '0;
      wb_data   <= '0;
      pc_wr_err <= 1'b0;
      rr        <= 1'b0;
    end else begin
      wb_en     <= gnt0 || gnt1;
      pc_wr_err <= (acc0 && !keep0) || (acc1 && !keep1);
      if (!empty0 && !empty1) rr <= !rr;
      if (gnt0) begin
        wb_dest <= head0.dest;
        wb_data <= head0.data;
      end else if (gnt1) begin
        wb_dest <= head1.dest;
        wb_data <= head1.data;
      end
    end
  end

  // A write retires the cycle after it is presented on wb_*.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (keep0 && int'(r0_dest) == int'(i)) cnt_nxt[i] = cnt_nxt[i] + CW'(1);
      if (keep1 && int'(r1_dest) == int'(i)) cnt_nxt[i] = cnt_nxt[i] + CW'(1);
      if (wb_en && int'(wb_dest) == int'(i)) cnt_nxt[i] = cnt_nxt[i] - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '{default: '0};
    else     cnt <= cnt_nxt;
  end

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) pending_mask[i] = (cnt[i] != '0);
  end

`ifdef RF_WB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt <= '0;
    else if (!empty0 && !empty1 && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: queue-level reference model plus negedge monitor.
module tb_rf_wb_arbiter;

  localparam int DW = 32, AW = 4, NR = 15, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_valid = 1'b0, r1_valid = 1'b0;
  logic          r0_ready, r1_ready;
  logic [AW-1:0] r0_dest = '0, r1_dest = '0;
  logic [DW-1:0] r0_data = '0, r1_data = '0;
  logic          wb_en;
  logic [AW-1:0] wb_dest;
  logic [DW-1:0] wb_data;
  logic [NR-1:0] pending_mask;
  logic          pc_wr_err;
`ifdef RF_WB_STATS_EN
  logic [31:0]   conflict_cnt;
`endif

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_dest(r0_dest), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_dest(r1_dest), .r1_data(r1_data),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .pending_mask(pending_mask), .pc_wr_err(pc_wr_err)
`ifdef RF_WB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { bit idle; logic [AW-1:0] dest; logic [DW-1:0] data; } stim_t;
  typedef struct { logic [AW-1:0] dest; logic [DW-1:0] data; } wr_t;

  stim_t s0[$], s1[$];
  wr_t   mq0[$], mq1[$], exp_wb[$];
  int    cnt[NR];
  bit    rr, exp_err, acc0_f, acc1_f, inflight_v, saw_full1;
  logic [AW-1:0] inflight_d;
  longint conflicts;
  int    checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: two queues, a round-robin bit, per-register outstanding counts.
  always @(posedge clk or posedge rst) begin : model
    bit  a0, a1, gv;
    wr_t g;
    if (rst) begin
      mq0.delete(); mq1.delete(); exp_wb.delete();
      foreach (cnt[i]) cnt[i] = 0;
      rr = 0; exp_err = 0; acc0_f = 0; acc1_f = 0; inflight_v = 0; conflicts = 0;
    end else begin
      a0 = r0_valid && (mq0.size() < DEPTH);
      a1 = r1_valid && (mq1.size() < DEPTH);
      if (inflight_v) cnt[inflight_d]--;
      gv = 1;
      if (mq0.size() > 0 && mq1.size() > 0) begin
        conflicts++;
        g  = rr ? mq1.pop_front() : mq0.pop_front();
        rr = !rr;
      end else if (mq0.size() > 0) g = mq0.pop_front();
      else if (mq1.size() > 0)     g = mq1.pop_front();
      else                         gv = 0;
      inflight_v = gv;
      inflight_d = g.dest;
      if (gv) exp_wb.push_back(g);
      exp_err = (a0 && r0_dest >= NR) || (a1 && r1_dest >= NR);
      if (a0 && r0_dest < NR) begin mq0.push_back('{dest: r0_dest, data: r0_data}); cnt[r0_dest]++; end
      if (a1 && r1_dest < NR) begin mq1.push_back('{dest: r1_dest, data: r1_data}); cnt[r1_dest]++; end
      acc0_f = a0;
      acc1_f = a1;
    end
  end

  // Monitor: pops an expected write whenever the DUT presents one.
  always @(negedge clk) begin : monitor
    wr_t e;
    logic [NR-1:0] em;
    if (!rst) begin
      chk("wb_en", wb_en, exp_wb.size() > 0);
      if (wb_en && exp_wb.size() > 0) begin
        e = exp_wb.pop_front();
        chk("wb_dest", wb_dest, e.dest);
        chk("wb_data", wb_data, e.data);
      end else if (exp_wb.size() > 0) begin
        exp_wb.delete(0);
      end
      for (int i = 0; i < NR; i++) em[i] = (cnt[i] != 0);
      chk("pending_mask", pending_mask, em);
      chk("r0_ready", r0_ready, mq0.size() < DEPTH);
      chk("r1_ready", r1_ready, mq1.size() < DEPTH);
      chk("pc_wr_err", pc_wr_err, exp_err);
`ifdef RF_WB_STATS_EN
      chk("conflict_cnt", conflict_cnt, conflicts);
`endif
      if (!r1_ready) saw_full1 = 1;
    end
  end

  task automatic drive();
    if (s0.size() > 0 && !s0[0].idle) begin
      r0_valid = 1; r0_dest = s0[0].dest; r0_data = s0[0].data;
    end else r0_valid = 0;
    if (s1.size() > 0 && !s1[0].idle) begin
      r1_valid = 1; r1_dest = s1[0].dest; r1_data = s1[0].data;
    end else r1_valid = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (s0.size() > 0 && (s0[0].idle || acc0_f)) s0.delete(0);
    if (s1.size() > 0 && (s1[0].idle || acc1_f)) s1.delete(0);
    drive();
  endtask

  task automatic drain(input string nm, input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      if (s0.size() == 0 && s1.size() == 0 && mq0.size() == 0 && mq1.size() == 0 && !inflight_v)
        done = 1;
    end
    chk({nm, "_drained"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_pc_err", pc_wr_err, 0);
    chk("rst_r0_ready", r0_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Single write: accept, issue next cycle, retire the cycle after.
    s0.push_back('{idle: 0, dest: 4'd3, data: 32'hDEADBEEF});
    drive();
    step();
    chk("t1_mask3_acc", pending_mask[3], 1);
    chk("t1_no_wb_yet", wb_en, 0);
    step();
    chk("t1_wb_en", wb_en, 1);
    chk("t1_wb_dest", wb_dest, 3);
    chk("t1_wb_data", wb_data, 32'hDEADBEEF);
    chk("t1_mask3_issue", pending_mask[3], 1);
    step();
    chk("t1_wb_off", wb_en, 0);
    chk("t1_mask3_retired", pending_mask[3], 0);

    // Both producers every cycle: alternating grants (r1 dests overlap r0 at reg 7).
    for (int i = 0; i < 8; i++) begin
      s0.push_back('{idle: 0, dest: AW'(i), data: 32'hA000_0000 + i});
      s1.push_back('{idle: 0, dest: AW'(7 + i), data: 32'hB000_0000 + i});
    end
    drive();
    drain("t2", 60);

    // Long r1 burst against r0 traffic: r1 FIFO must fill and back-pressure.
    saw_full1 = 0;
    for (int i = 0; i < 12; i++) s0.push_back('{idle: 0, dest: AW'(i % 7), data: $urandom});
    for (int i = 0; i < 8; i++)  s1.push_back('{idle: 0, dest: AW'(7 + i), data: $urandom});
    drive();
    drain("t3", 80);
    chk("t3_r1_backpressure", saw_full1, 1);

    // Write to PC index: handshake completes, error pulse, nothing issued.
    s0.push_back('{idle: 0, dest: 4'd15, data: 32'h1234});
    drive();
    chk("t4_ready", r0_ready, 1);
    step();
    chk("t4_err_pulse", pc_wr_err, 1);
    chk("t4_mask", pending_mask, 0);
    step();
    chk("t4_err_clear", pc_wr_err, 0);
    chk("t4_no_wb", wb_en, 0);

    // Same destination from both sides in one cycle.
    s0.push_back('{idle: 0, dest: 4'd7, data: 32'h7777_0000});
    s1.push_back('{idle: 0, dest: 4'd7, data: 32'h7777_0001});
    drive();
    step();
    chk("t5_mask7", pending_mask[7], 1);
    step();
    chk("t5_mask7_first_issue", pending_mask[7], 1);
    step();
    chk("t5_mask7_second_issue", pending_mask[7], 1);
    drain("t5", 10);
    chk("t5_mask7_retired", pending_mask[7], 0);

    // Reset in the middle of a burst discards everything queued.
    for (int i = 0; i < 6; i++) begin
      s0.push_back('{idle: 0, dest: AW'(i), data: $urandom});
      s1.push_back('{idle: 0, dest: AW'(8 + i), data: $urandom});
    end
    drive();
    repeat (3) step();
    #3 rst = 1;
    #1;
    chk("t6_wb_en_rst", wb_en, 0);
    chk("t6_mask_rst", pending_mask, 0);
    s0.delete(); s1.delete();
    drive();
    #10 rst = 0;
    repeat (5) step();
    chk("t6_idle_after_rst", wb_en, 0);

    // Randomised traffic, including gaps and PC-index writes.
    for (int i = 0; i < 200; i++) begin
      s0.push_back('{idle: ($urandom_range(0, 3) == 0), dest: AW'($urandom_range(0, 15)), data: $urandom});
      s1.push_back('{idle: ($urandom_range(0, 2) == 0), dest: AW'($urandom_range(0, 15)), data: $urandom});
    end
    drive();
    drain("rand", 2000);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
